pipe_control_unit: RTL and testbench
====================================

Name: pipe_control_unit

Overview:
- Parametrised successor to the single-cycle MIPS decoder.
- Decodes op/func in the D stage and carries the control bundle through registered E, M and W stages.
- Detects load-use and branch/jr data hazards, and generates the F/D stall and E bubble.
- Adds full decoding of jal (link to $31) and jr, plus an illegal-instruction flag with guaranteed NOP controls; the previous decoder has neither.
- Sits between the IF/ID register and the datapath of the 5-stage pipeline.

Parameters:
- ALU_W, 4, width of the ALU control field; codes are zero-extended when ALU_W > 4 (ALU_W >= 4 required).
- REG_AW, 5, register-address width.
- BR_FWD_M, 1, 1 = D-stage branch compare has an M-stage forward path, so no M-stage stall for ALU results.

Ports:
- CLK  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid_d  in  1  D-stage instruction is real (0 = treat as NOP).
- op_d  in  6  opcode.
- func_d  in  6  R-type function.
- rs_d, rt_d, rd_d  in  REG_AW each  register fields.
- flush_e  in  1  kill the instruction entering E (taken branch/jump).
- stall_fd  out  1  hold PC and IF/ID (combinational).
- branch_d, bne_d, jump_d, jr_d, illegal_d  out  1 each  combinational D decode.
- regwrite_e, memtoreg_e, memwrite_e, alusrc_e, shamt_e, regdst_e, link_e  out  1 each  E-stage registered.
- alucontrol_e  out  ALU_W  E-stage ALU code.
- writereg_e  out  REG_AW  E destination.
- regwrite_m, memtoreg_m, memwrite_m  out  1 each.
- writereg_m  out  REG_AW.
- regwrite_w, memtoreg_w, link_w  out  1 each.
- writereg_w  out  REG_AW.

Behaviour:
- Clock and reset: one clock CLK; reset is synchronous and active-high.
- ALU codes:
  - add/addu/lw/sw/addi/addiu 0010; sub/subu 0110.
  - and 0000, or 0001, xor 0011, nor 1100.
  - sll/sllv 0100, srl/srlv 0101, sra/srav 1000, slt 0111.
  - andi 1111, ori 1101, xori 1110.
  - beq 1001, bne 1010; j/jal 1101; jr 1110.
- Decode flags:
  - shamt = 1 only for sll/srl/sra. regdst = 1 for all R-type except jr.
  - alusrc = 1 for lw/sw/addi/addiu/andi/ori/xori.
  - memtoreg and regwrite are set for lw; memwrite is set for sw.
  - jal: regwrite = 1, link = 1, destination forced to 31.
  - jump_d = 1 for j/jal; jr_d = 1 for R-type func 001000; branch_d = 1 for beq/bne; bne_d = 1 for bne only.
- Illegal instructions: any unlisted op, or an unlisted func under op 000000, sets illegal_d = 1 when instr_valid_d = 1. All write enables, branch and jump flags are then 0 and the ALU code is 0010. No latched values from previous instructions.
- instr_valid_d = 0 produces all-zero decode, including illegal_d.
- Destination: writereg = 31 if jal, else rd_d if regdst, else rt_d.
- Register usage:
  - use_rs = 0 for sll/srl/sra/j/jal; 1 otherwise.
  - use_rt = 1 for R-type (except jr), beq, bne, sw.
- Hazard conditions (all gated by instr_valid_d; a match means the address is nonzero and equal):
  - Load-use stall: memtoreg_e and writereg_e matches a used rs_d/rt_d.
  - Branch stall: (branch_d or jr_d) and regwrite_e and writereg_e matches a used source.
  - M-stage branch stall: (branch_d or jr_d) and writereg_m matches, and either memtoreg_m, or regwrite_m with BR_FWD_M = 0.
  - stall_fd = OR of the above.
- Pipeline stepping, each edge:
  - E <= bubble if reset | flush_e | stall_fd, else the D decode.
  - M <= E and W <= M, unconditionally (a stall never freezes M/W).
  - Bubble = all control bits 0, alucontrol 0, writereg 0.
- Simultaneous flush_e and stall_fd: a single bubble; stall_fd still asserts so F/D holds.
- Reset mid-operation: E, M and W all clear on the same edge.
- Reset values of all registered outputs are 0.
- Latency: decode to E outputs in 1 cycle, to M in 2, to W in 3.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - opcode and func constants.
  - ALU code constants (4-bit base).
  - Packed control-bundle struct (regwrite, memtoreg, memwrite, alusrc, shamt, regdst, link, alucontrol, writereg).
  - BUBBLE constant.
- Sub-module ctrl_decode: pure combinational op/func to bundle plus flags.
- Hazard logic and stage registers stay in the top.

Test Plan:
- Reset: hold reset 2 cycles with add decoding → all E/M/W outputs 0. Release → add (func 100000, rd=3) gives regwrite_e=1, alucontrol_e=0010, writereg_e=3, then regwrite_w=1 three cycles after decode.
- Load-use stall: lw $5 in E, then add $6,$5,$7 in D → stall_fd=1 for exactly 1 cycle; E bubble (regwrite_e=0); add enters E the next cycle. Same with sll $6,$5,2 (rt=5 used) stalls, but lw $0 never stalls.
- Branch hazard: addi $4 in E, beq $4,$2 in D → 1-cycle stall. lw $4 in M with beq $4 in D → stall (any BR_FWD_M). With BR_FWD_M=1, an ALU result in M → no stall.
- jal: op 000011 → regwrite_e=1, link_e=1, writereg_e=31, and link_w=1 three cycles later. jr (func 001000) → jr_d=1, regwrite_e=0.
- Illegal: op 111111 valid → illegal_d=1, E all write enables 0, alucontrol_e=0010. Same op with instr_valid_d=0 → illegal_d=0.
- Simultaneous events: flush_e=1 with load-use stall → one bubble, stall_fd=1. Reset asserted while lw is in M → regwrite_w=0 and memtoreg_w=0 after the edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/func encodings, ALU codes and the control bundle carried
// through the E/M/W stage registers of the pipelined control unit.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ANDI = 4'b1111;
  localparam logic [3:0] ALU_ORI  = 4'b1101;
  localparam logic [3:0] ALU_XORI = 4'b1110;
  localparam logic [3:0] ALU_BEQ  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;
  localparam logic [3:0] ALU_JUMP = 4'b1101;
  localparam logic [3:0] ALU_JR   = 4'b1110;

  // Destination address travels next to this bundle because its width is a
  // module parameter (REG_AW) and packages cannot be parameterised.
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       shamt;
    logic       regdst;
    logic       link;
    logic [3:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t BUBBLE   = '0;
  localparam ctrl_t CTRL_NOP = ctrl_t'({7'b0, ALU_ADD});

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational D-stage decode: op/func to control bundle, destination,
// branch/jump flags, illegal flag and source-register usage.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              instr_valid,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  output ctrl_t             ctrl,
  output logic [REG_AW-1:0] writereg,
  output logic              branch,
  output logic              bne,
  output logic              jump,
  output logic              jr,
  output logic              illegal,
  output logic              use_rs,
  output logic              use_rt
);

  logic legal;

  always_comb begin
    ctrl     = CTRL_NOP;
    writereg = '0;
    branch   = 1'b0;
    bne      = 1'b0;
    jump     = 1'b0;
    jr       = 1'b0;
    illegal  = 1'b0;
    use_rs   = 1'b1;
    use_rt   = 1'b0;
    legal    = 1'b1;

    case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        use_rt        = 1'b1;
        case (func)
          FN_ADD, FN_ADDU: ctrl.alucontrol = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alucontrol = ALU_SUB;
          FN_AND:          ctrl.alucontrol = ALU_AND;
          FN_OR:           ctrl.alucontrol = ALU_OR;
          FN_XOR:          ctrl.alucontrol = ALU_XOR;
          FN_NOR:          ctrl.alucontrol = ALU_NOR;
          FN_SLT:          ctrl.alucontrol = ALU_SLT;
          FN_SLLV:         ctrl.alucontrol = ALU_SLL;
          FN_SRLV:         ctrl.alucontrol = ALU_SRL;
          FN_SRAV:         ctrl.alucontrol = ALU_SRA;
          FN_SLL, FN_SRL, FN_SRA: begin
            ctrl.shamt      = 1'b1;
            use_rs          = 1'b0;
            ctrl.alucontrol = (func == FN_SLL) ? ALU_SLL :
                              (func == FN_SRL) ? ALU_SRL : ALU_SRA;
          end
          FN_JR: begin
            ctrl.regwrite   = 1'b0;
            ctrl.regdst     = 1'b0;
            ctrl.alucontrol = ALU_JR;
            jr              = 1'b1;
            use_rt          = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_J: begin
        jump            = 1'b1;
        use_rs          = 1'b0;
        ctrl.alucontrol = ALU_JUMP;
      end
      OP_JAL: begin
        jump            = 1'b1;
        use_rs          = 1'b0;
        ctrl.regwrite   = 1'b1;
        ctrl.link       = 1'b1;
        ctrl.alucontrol = ALU_JUMP;
      end
      OP_BEQ: begin
        branch          = 1'b1;
        use_rt          = 1'b1;
        ctrl.alucontrol = ALU_BEQ;
      end
      OP_BNE: begin
        branch          = 1'b1;
        bne             = 1'b1;
        use_rt          = 1'b1;
        ctrl.alucontrol = ALU_BNE;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alusrc     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.alucontrol = (op == OP_ANDI) ? ALU_ANDI :
                          (op == OP_ORI)  ? ALU_ORI  :
                          (op == OP_XORI) ? ALU_XORI : ALU_ADD;
      end
      OP_LW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      OP_SW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        use_rt        = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (ctrl.link)        writereg = REG_AW'(5'd31);
    else if (ctrl.regdst) writereg = rd;
    else                  writereg = rt;

    // Illegal encodings fall back to a clean NOP bundle, never a partial decode.
    if (!legal) begin
      ctrl     = CTRL_NOP;
      writereg = '0;
      branch   = 1'b0;
      bne      = 1'b0;
      jump     = 1'b0;
      jr       = 1'b0;
      illegal  = 1'b1;
    end

    if (!instr_valid) begin
      ctrl     = BUBBLE;
      writereg = '0;
      branch   = 1'b0;
      bne      = 1'b0;
      jump     = 1'b0;
      jr       = 1'b0;
      illegal  = 1'b0;
      use_rs   = 1'b0;
      use_rt   = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: D-stage decode, load-use/branch hazard stall and
// the registered E/M/W control stages.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int ALU_W    = 4,
  parameter int REG_AW   = 5,
  parameter int BR_FWD_M = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              instr_valid_d,
  input  logic [5:0]        op_d,
  input  logic [5:0]        func_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              flush_e,
  output logic              stall_fd,
  output logic              branch_d,
  output logic              bne_d,
  output logic              jump_d,
  output logic              jr_d,
  output logic              illegal_d,
  output logic              regwrite_e,
  output logic              memtoreg_e,
  output logic              memwrite_e,
  output logic              alusrc_e,
  output logic              shamt_e,
  output logic              regdst_e,
  output logic              link_e,
  output logic [ALU_W-1:0]  alucontrol_e,
  output logic [REG_AW-1:0] writereg_e,
  output logic              regwrite_m,
  output logic              memtoreg_m,
  output logic              memwrite_m,
  output logic [REG_AW-1:0] writereg_m,
  output logic              regwrite_w,
  output logic              memtoreg_w,
  output logic              link_w,
  output logic [REG_AW-1:0] writereg_w
);

  ctrl_t             dec_ctrl;
  logic [REG_AW-1:0] dec_wr;
  logic              use_rs, use_rt;

  ctrl_t             e_ctrl;
  logic [REG_AW-1:0] e_wr;
  logic              m_regwrite, m_memtoreg, m_memwrite, m_link;
  logic [REG_AW-1:0] m_wr;
  logic              w_regwrite, w_memtoreg, w_link;
  logic [REG_AW-1:0] w_wr;

  logic src_hit_e, src_hit_m, br_or_jr;
  logic load_use_stall, branch_stall, branch_m_stall;

  ctrl_decode #(.REG_AW(REG_AW)) u_decode (
    .instr_valid (instr_valid_d),
    .op          (op_d),
    .func        (func_d),
    .rt          (rt_d),
    .rd          (rd_d),
    .ctrl        (dec_ctrl),
    .writereg    (dec_wr),
    .branch      (branch_d),
    .bne         (bne_d),
    .jump        (jump_d),
    .jr          (jr_d),
    .illegal     (illegal_d),
    .use_rs      (use_rs),
    .use_rt      (use_rt)
  );

  // $0 is never a real producer, so a zero address never matches.
  function automatic logic addr_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    src_hit_e = (use_rs && addr_hit(rs_d, e_wr)) || (use_rt && addr_hit(rt_d, e_wr));
    src_hit_m = (use_rs && addr_hit(rs_d, m_wr)) || (use_rt && addr_hit(rt_d, m_wr));
    br_or_jr  = branch_d || jr_d;

    load_use_stall = instr_valid_d && e_ctrl.memtoreg && src_hit_e;
    branch_stall   = instr_valid_d && br_or_jr && e_ctrl.regwrite && src_hit_e;
    branch_m_stall = instr_valid_d && br_or_jr && src_hit_m &&
                     (m_memtoreg || (m_regwrite && (BR_FWD_M == 0)));

    stall_fd = load_use_stall || branch_stall || branch_m_stall;
  end

  // M and W always advance; only E takes a bubble on stall or flush.
  always_ff @(posedge CLK) begin
    if (reset) begin
      e_ctrl     <= BUBBLE;
      e_wr       <= '0;
      m_regwrite <= 1'b0;
      m_memtoreg <= 1'b0;
      m_memwrite <= 1'b0;
      m_link     <= 1'b0;
      m_wr       <= '0;
      w_regwrite <= 1'b0;
      w_memtoreg <= 1'b0;
      w_link     <= 1'b0;
      w_wr       <= '0;
    end else begin
      if (flush_e || stall_fd) begin
        e_ctrl <= BUBBLE;
        e_wr   <= '0;
      end else begin
        e_ctrl <= dec_ctrl;
        e_wr   <= dec_wr;
      end
      m_regwrite <= e_ctrl.regwrite;
      m_memtoreg <= e_ctrl.memtoreg;
      m_memwrite <= e_ctrl.memwrite;
      m_link     <= e_ctrl.link;
      m_wr       <= e_wr;
      w_regwrite <= m_regwrite;
      w_memtoreg <= m_memtoreg;
      w_link     <= m_link;
      w_wr       <= m_wr;
    end
  end

  assign regwrite_e   = e_ctrl.regwrite;
  assign memtoreg_e   = e_ctrl.memtoreg;
  assign memwrite_e   = e_ctrl.memwrite;
  assign alusrc_e     = e_ctrl.alusrc;
  assign shamt_e      = e_ctrl.shamt;
  assign regdst_e     = e_ctrl.regdst;
  assign link_e       = e_ctrl.link;
  assign alucontrol_e = ALU_W'(e_ctrl.alucontrol);
  assign writereg_e   = e_wr;

  assign regwrite_m = m_regwrite;
  assign memtoreg_m = m_memtoreg;
  assign memwrite_m = m_memwrite;
  assign writereg_m = m_wr;

  assign regwrite_w = w_regwrite;
  assign memtoreg_w = w_memtoreg;
  assign link_w     = w_link;
  assign writereg_w = w_wr;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: expected E bundles are queued at
// drive time and compared after the edge, then followed down M and W.
module tb_pipe_control_unit;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid_d = 1'b0;
  logic [5:0] op_d = '0, func_d = '0;
  logic [4:0] rs_d = '0, rt_d = '0, rd_d = '0;
  logic       flush_e = 1'b0;
  logic       stall_fd, branch_d, bne_d, jump_d, jr_d, illegal_d;
  logic       regwrite_e, memtoreg_e, memwrite_e, alusrc_e, shamt_e, regdst_e, link_e;
  logic [3:0] alucontrol_e;
  logic [4:0] writereg_e, writereg_m, writereg_w;
  logic       regwrite_m, memtoreg_m, memwrite_m;
  logic       regwrite_w, memtoreg_w, link_w;

  always #5 CLK = ~CLK;

  pipe_control_unit dut (
    .CLK(CLK), .reset(reset), .instr_valid_d(instr_valid_d),
    .op_d(op_d), .func_d(func_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .flush_e(flush_e), .stall_fd(stall_fd),
    .branch_d(branch_d), .bne_d(bne_d), .jump_d(jump_d), .jr_d(jr_d), .illegal_d(illegal_d),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
    .alusrc_e(alusrc_e), .shamt_e(shamt_e), .regdst_e(regdst_e), .link_e(link_e),
    .alucontrol_e(alucontrol_e), .writereg_e(writereg_e),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
    .writereg_m(writereg_m),
    .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w), .link_w(link_w),
    .writereg_w(writereg_w)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // bundle [20:5] = rw mtr mw asrc sh rdst lnk alu[3:0] wr[4:0]; [4:0] = br bn jp jr ill
  typedef struct packed {
    logic rw, mtr, mw, asrc, sh, rdst, lnk;
    logic [3:0] alu;
    logic [4:0] wr;
    logic br, bn, jp, jr, ill;
  } dec_t;

  function automatic dec_t model(input logic v, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] rt, input logic [4:0] rd);
    dec_t e;
    e = '0;
    if (!v) return e;
    e.alu = 4'b0010;
    e.wr  = rt;
    case (op)
      6'd0: begin
        e.rw = 1'b1; e.rdst = 1'b1; e.wr = rd;
        case (fn)
          6'd32, 6'd33: e.alu = 4'b0010;
          6'd34, 6'd35: e.alu = 4'b0110;
          6'd36: e.alu = 4'b0000;
          6'd37: e.alu = 4'b0001;
          6'd38: e.alu = 4'b0011;
          6'd39: e.alu = 4'b1100;
          6'd42: e.alu = 4'b0111;
          6'd4:  e.alu = 4'b0100;
          6'd6:  e.alu = 4'b0101;
          6'd7:  e.alu = 4'b1000;
          6'd0:  begin e.alu = 4'b0100; e.sh = 1'b1; end
          6'd2:  begin e.alu = 4'b0101; e.sh = 1'b1; end
          6'd3:  begin e.alu = 4'b1000; e.sh = 1'b1; end
          6'd8:  begin e.rw = 1'b0; e.rdst = 1'b0; e.wr = rt; e.jr = 1'b1; e.alu = 4'b1110; end
          default: begin e = '0; e.alu = 4'b0010; e.ill = 1'b1; end
        endcase
      end
      6'd2:  begin e.jp = 1'b1; e.alu = 4'b1101; end
      6'd3:  begin e.jp = 1'b1; e.rw = 1'b1; e.lnk = 1'b1; e.alu = 4'b1101; e.wr = 5'd31; end
      6'd4:  begin e.br = 1'b1; e.alu = 4'b1001; end
      6'd5:  begin e.br = 1'b1; e.bn = 1'b1; e.alu = 4'b1010; end
      6'd8, 6'd9: begin e.asrc = 1'b1; e.rw = 1'b1; end
      6'd12: begin e.asrc = 1'b1; e.rw = 1'b1; e.alu = 4'b1111; end
      6'd13: begin e.asrc = 1'b1; e.rw = 1'b1; e.alu = 4'b1101; end
      6'd14: begin e.asrc = 1'b1; e.rw = 1'b1; e.alu = 4'b1110; end
      6'd35: begin e.asrc = 1'b1; e.rw = 1'b1; e.mtr = 1'b1; end
      6'd43: begin e.asrc = 1'b1; e.mw = 1'b1; end
      default: begin e = '0; e.alu = 4'b0010; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  logic [15:0] q_e[$];
  logic [15:0] exp_e = '0, exp_m = '0, exp_w = '0;

  task automatic step(input logic rst, input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic fl, input logic exp_stall);
    dec_t d;
    @(negedge CLK);
    reset = rst; instr_valid_d = v; op_d = op; func_d = fn;
    rs_d = rs; rt_d = rt; rd_d = rd; flush_e = fl;
    #1;
    d = model(v, op, fn, rt, rd);
    check_eq("stall_fd", 32'(stall_fd), 32'(exp_stall));
    check_eq("d_flags", 32'({branch_d, bne_d, jump_d, jr_d, illegal_d}), 32'(d[4:0]));
    q_e.push_back((rst || fl || exp_stall) ? 16'h0 : d[20:5]);
    @(posedge CLK);
    #1;
    exp_w = rst ? 16'h0 : exp_m;
    exp_m = rst ? 16'h0 : exp_e;
    exp_e = q_e.pop_front();
    check_eq("e_bundle", 32'({regwrite_e, memtoreg_e, memwrite_e, alusrc_e, shamt_e, regdst_e,
                              link_e, alucontrol_e, writereg_e}), 32'(exp_e));
    check_eq("m_bundle", 32'({regwrite_m, memtoreg_m, memwrite_m, writereg_m}),
             32'({exp_m[15:13], exp_m[4:0]}));
    check_eq("w_bundle", 32'({regwrite_w, memtoreg_w, link_w, writereg_w}),
             32'({exp_w[15], exp_w[14], exp_w[9], exp_w[4:0]}));
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  logic [11:0] alu_list[15] = '{
    {6'd0, 6'd34}, {6'd0, 6'd36}, {6'd0, 6'd37}, {6'd0, 6'd38}, {6'd0, 6'd39},
    {6'd0, 6'd42}, {6'd0, 6'd7},  {6'd0, 6'd2},  {6'd12, 6'd0}, {6'd13, 6'd0},
    {6'd14, 6'd0}, {6'd43, 6'd0}, {6'd5, 6'd0},  {6'd2, 6'd0},  {6'd9, 6'd0}
  };

  initial begin
    @(posedge CLK);
    #1;
    // reset held with add decoding
    step(1'b1, 1'b1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    // add $3 travels to W
    step(1'b0, 1'b1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    nop(); nop(); nop();
    // load-use on rs
    step(1'b0, 1'b1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd0, 6'd32, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1);
    step(1'b0, 1'b1, 6'd0, 6'd32, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
    // load-use on rt of sll
    step(1'b0, 1'b1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd0, 6'd0, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1);
    step(1'b0, 1'b1, 6'd0, 6'd0, 5'd0, 5'd5, 5'd6, 1'b0, 1'b0);
    // sll ignores rs
    step(1'b0, 1'b1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd0, 6'd0, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
    // lw $0 never stalls
    step(1'b0, 1'b1, 6'd35, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd0, 6'd32, 5'd0, 5'd7, 5'd6, 1'b0, 1'b0);
    // branch on ALU result in E, then forwarded from M
    step(1'b0, 1'b1, 6'd8, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd4, 6'd0, 5'd4, 5'd2, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 6'd4, 6'd0, 5'd4, 5'd2, 5'd0, 1'b0, 1'b0);
    // branch on load in M
    step(1'b0, 1'b1, 6'd35, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
    nop();
    step(1'b0, 1'b1, 6'd4, 6'd0, 5'd4, 5'd2, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 6'd4, 6'd0, 5'd4, 5'd2, 5'd0, 1'b0, 1'b0);
    // jal link to W, then jr
    step(1'b0, 1'b1, 6'd3, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nop(); nop(); nop();
    step(1'b0, 1'b1, 6'd0, 6'd8, 5'd31, 5'd0, 5'd0, 1'b0, 1'b0);
    // illegal valid / invalid
    step(1'b0, 1'b1, 6'd63, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 6'd63, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd0, 6'd63, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    // flush together with load-use stall
    step(1'b0, 1'b1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd0, 6'd32, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1);
    step(1'b0, 1'b1, 6'd0, 6'd32, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
    // reset while lw is in M
    step(1'b0, 1'b1, 6'd35, 6'd0, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0);
    nop();
    step(1'b1, 1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nop();
    // flush alone
    step(1'b0, 1'b1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    nop();
    // remaining ALU codes
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, alu_list[i][11:6], alu_list[i][5:0], 5'd1, 5'd2, 5'd10, 1'b0, 1'b0);
      nop(); nop();
    end
    nop(); nop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
